// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyphs, converter FSM states and
// the digit-to-glyph mapping used by every display digit.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [3:0] DIGIT_DASH = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        INT_CVT,
        FRAC_CVT,
        UPDATE
    } state_t;

    // Non-decimal codes (10..15) render as a dash; this carries sign and saturation.
    function automatic logic [6:0] digit_glyph(input logic [3:0] digit, input logic blank);
        logic [6:0] g;
        if (blank) begin
            g = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    g = SEG_0;
                4'd1:    g = SEG_1;
                4'd2:    g = SEG_2;
                4'd3:    g = SEG_3;
                4'd4:    g = SEG_4;
                4'd5:    g = SEG_5;
                4'd6:    g = SEG_6;
                4'd7:    g = SEG_7;
                4'd8:    g = SEG_8;
                4'd9:    g = SEG_9;
                default: g = SEG_DASH;
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// One display digit: BCD code plus blank flag to an active-low segment glyph.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] glyph
);

    assign glyph = digit_glyph(digit, blank);

endmodule

// File: rtl/fixed_point_hex_display.sv
// Serial signed fixed-point to seven-segment converter: sign digit, INT_DIGITS
// integer digits (shift-add-3) and FRAC_DIGITS truncated fraction digits (times-10).
module fixed_point_hex_display
    import seg7_pkg::*;
#(
    parameter int W           = 27,
    parameter int FRAC        = 22,
    parameter int INT_DIGITS  = 2,
    parameter int FRAC_DIGITS = 3,
    parameter int BLANK_LZ    = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [W-1:0]                          value,
    output logic                                  in_ready,
    output logic [INT_DIGITS+FRAC_DIGITS:0][6:0]  hex,
    output logic                                  done,
    output logic                                  ovf
);

    localparam int IW   = W - FRAC;
    localparam int ND   = 1 + INT_DIGITS + FRAC_DIGITS;
    localparam int FD_N = (FRAC_DIGITS > 0) ? FRAC_DIGITS : 1;
    localparam int BW   = 4 * INT_DIGITS;
    localparam int FBW  = 4 * FD_N;
    localparam int CW   = $clog2(W + 1) + 1;
    localparam int LW   = (IW > 14) ? IW : 14;

    localparam logic [LW-1:0] LIMIT     = LW'(10 ** INT_DIGITS);
    localparam logic [CW-1:0] INT_LAST  = CW'(IW - 1);
    localparam logic [CW-1:0] FRAC_LAST = CW'(FRAC_DIGITS - 1);

    state_t state, next_state;

    logic [W-1:0]     sample;
    logic             neg;
    logic [IW-1:0]    int_sh;
    logic [FRAC-1:0]  frac_reg;
    logic [BW-1:0]    bcd;
    logic [FBW-1:0]   fbcd;
    logic             sat;
    logic [CW-1:0]    cnt;

    logic [W-1:0]     mag_c;
    logic [LW-1:0]    int_ext;
    logic             sat_c;
    logic [BW-1:0]    bcd_adj;
    logic [FRAC+3:0]  prod;
    logic             lz_run;

    logic [ND-1:0][3:0] enc_digit;
    logic [ND-1:0]      enc_blank;
    logic [ND-1:0][6:0] enc_glyph;

    assign in_ready = (state == IDLE);

    // Unsigned magnitude is one bit wider in range than the signed input, so -2^(W-1) stays exact.
    always_comb begin
        mag_c   = sample[W-1] ? (~sample + 1'b1) : sample;
        int_ext = LW'(mag_c[W-1:FRAC]);
        sat_c   = (int_ext >= LIMIT);
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        prod = ({4'b0000, frac_reg} << 3) + ({4'b0000, frac_reg} << 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (in_valid) next_state = ABS;
            ABS:      next_state = INT_CVT;
            INT_CVT:  if (cnt == INT_LAST) next_state = (FRAC_DIGITS > 0) ? FRAC_CVT : UPDATE;
            FRAC_CVT: if (cnt == FRAC_LAST) next_state = UPDATE;
            UPDATE:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample   <= '0;
            neg      <= 1'b0;
            int_sh   <= '0;
            frac_reg <= '0;
            bcd      <= '0;
            fbcd     <= '0;
            sat      <= 1'b0;
            cnt      <= '0;
            hex      <= {ND{SEG_BLANK}};
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) sample <= value;
                end
                ABS: begin
                    neg      <= sample[W-1];
                    int_sh   <= mag_c[W-1:FRAC];
                    frac_reg <= mag_c[FRAC-1:0];
                    sat      <= sat_c;
                    bcd      <= '0;
                    fbcd     <= '0;
                    cnt      <= '0;
                end
                INT_CVT: begin
                    bcd    <= BW'({bcd_adj, int_sh[IW-1]});
                    int_sh <= int_sh << 1;
                    cnt    <= (cnt == INT_LAST) ? '0 : cnt + 1'b1;
                end
                FRAC_CVT: begin
                    fbcd     <= (fbcd << 4) | FBW'(prod[FRAC+3:FRAC]);
                    frac_reg <= prod[FRAC-1:0];
                    cnt      <= cnt + 1'b1;
                end
                UPDATE: begin
                    hex  <= enc_glyph;
                    ovf  <= sat;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blanking walks down from the top integer digit and never reaches the units digit.
    always_comb begin
        enc_digit = '0;
        enc_blank = '0;
        lz_run    = 1'b1;
        for (int i = 0; i < FRAC_DIGITS; i++) begin
            enc_digit[i] = sat ? DIGIT_DASH : fbcd[4*i +: 4];
        end
        for (int j = 0; j < INT_DIGITS; j++) begin
            enc_digit[FRAC_DIGITS+j] = sat ? DIGIT_DASH : bcd[4*j +: 4];
        end
        for (int j = INT_DIGITS - 1; j >= 1; j--) begin
            lz_run = lz_run & (bcd[4*j +: 4] == 4'd0);
            enc_blank[FRAC_DIGITS+j] = lz_run & ~sat & (BLANK_LZ != 0);
        end
        enc_digit[ND-1] = DIGIT_DASH;
        enc_blank[ND-1] = ~neg;
    end

    for (genvar g = 0; g < ND; g++) begin : g_enc
        seg7_encode u_enc (
            .digit (enc_digit[g]),
            .blank (enc_blank[g]),
            .glyph (enc_glyph[g])
        );
    end

endmodule

// File: tb/tb_fixed_point_hex_display.sv
// Directed bench: default converter plus a one-integer-digit instance for saturation.
module tb_fixed_point_hex_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GB = 7'b1111111;
    localparam logic [6:0] GD = 7'b0111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vld0 = 1'b0, vld1 = 1'b0;
    logic [26:0] val0 = '0, val1 = '0;
    logic        rdy0, rdy1, done0, done1, ovf0, ovf1;
    logic [5:0][6:0] hex0;
    logic [4:0][6:0] hex1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fixed_point_hex_display dut0 (
        .clk(clk), .reset(reset), .in_valid(vld0), .value(val0),
        .in_ready(rdy0), .hex(hex0), .done(done0), .ovf(ovf0)
    );

    fixed_point_hex_display #(.INT_DIGITS(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(vld1), .value(val1),
        .in_ready(rdy1), .hex(hex1), .done(done1), .ovf(ovf1)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic run_sample(input bit sel, input logic [26:0] v, output int lat, output bit stable);
        logic [41:0] snap;
        lat = -1;
        stable = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 50 && !(sel ? rdy1 : rdy0); w++) @(negedge clk);
        if (sel) begin val1 = v; vld1 = 1'b1; end
        else     begin val0 = v; vld0 = 1'b1; end
        snap = sel ? 42'(hex1) : hex0;
        @(posedge clk); #1;
        vld0 = 1'b0;
        vld1 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (sel ? done1 : done0) begin
                lat = n;
                break;
            end
            if ((sel ? 42'(hex1) : hex0) !== snap) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nvec++; if (hex0 !== {6{GB}}) begin nerr++; $display("[TB] FAIL reset_hex0 got %h want %h", hex0, {6{GB}}); end
        nvec++; if (hex1 !== {5{GB}}) begin nerr++; $display("[TB] FAIL reset_hex1 got %h want %h", hex1, {5{GB}}); end
        nvec++; if (done0 !== 1'b0 || ovf0 !== 1'b0) begin nerr++; $display("[TB] FAIL reset_flags got done=%b ovf=%b want 0 0", done0, ovf0); end
        reset = 1'b0;
        #1;
        nvec++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin nerr++; $display("[TB] FAIL reset_ready got %b%b want 11", rdy0, rdy1); end
    endtask

    task automatic test_basic();
        int lat;
        bit stable;
        run_sample(1'b0, 27'h0440000, lat, stable);
        nvec++; if (lat !== 10) begin nerr++; $display("[TB] FAIL basic_latency got %0d want 10", lat); end
        nvec++; if (stable !== 1'b1) begin nerr++; $display("[TB] FAIL basic_hold got unstable want stable"); end
        nvec++; if (hex0 !== {GB, GB, G1, G0, G6, G2}) begin nerr++; $display("[TB] FAIL basic_hex got %h want %h", hex0, {GB, GB, G1, G0, G6, G2}); end
        nvec++; if (ovf0 !== 1'b0) begin nerr++; $display("[TB] FAIL basic_ovf got %b want 0", ovf0); end
        @(posedge clk); #1;
        nvec++; if (done0 !== 1'b0) begin nerr++; $display("[TB] FAIL basic_done_pulse got %b want 0", done0); end
    endtask

    task automatic test_negative();
        logic [26:0] vals [3];
        logic [41:0] exps [3];
        int lat;
        bit stable;
        vals[0] = 27'h7600000; exps[0] = {GD, GB, G2, G5, G0, G0};
        vals[1] = 27'h4000000; exps[1] = {GD, G1, G6, G0, G0, G0};
        vals[2] = 27'h7FFFFFF; exps[2] = {GD, GB, G0, G0, G0, G0};
        for (int i = 0; i < 3; i++) begin
            run_sample(1'b0, vals[i], lat, stable);
            nvec++; if (lat !== 10) begin nerr++; $display("[TB] FAIL neg%0d_latency got %0d want 10", i, lat); end
            nvec++; if (hex0 !== exps[i]) begin nerr++; $display("[TB] FAIL neg%0d_hex got %h want %h", i, hex0, exps[i]); end
            nvec++; if (ovf0 !== 1'b0) begin nerr++; $display("[TB] FAIL neg%0d_ovf got %b want 0", i, ovf0); end
        end
    endtask

    task automatic test_fraction();
        logic [26:0] vals [4];
        logic [41:0] exps [4];
        int lat;
        bit stable;
        vals[0] = 27'h03FFFFF; exps[0] = {GB, GB, G0, G9, G9, G9};
        vals[1] = 27'h2A00000; exps[1] = {GB, G1, G0, G5, G0, G0};
        vals[2] = 27'h0000000; exps[2] = {GB, GB, G0, G0, G0, G0};
        vals[3] = 27'h3FFFFFF; exps[3] = {GB, G1, G5, G9, G9, G9};
        for (int i = 0; i < 4; i++) begin
            run_sample(1'b0, vals[i], lat, stable);
            nvec++; if (stable !== 1'b1) begin nerr++; $display("[TB] FAIL frac%0d_hold got unstable want stable", i); end
            nvec++; if (hex0 !== exps[i]) begin nerr++; $display("[TB] FAIL frac%0d_hex got %h want %h", i, hex0, exps[i]); end
        end
    endtask

    task automatic test_saturation();
        logic [26:0] vals [3];
        logic [34:0] exps [3];
        logic        ovfs [3];
        int lat;
        bit stable;
        vals[0] = 27'h3000000; exps[0] = {GB, GD, GD, GD, GD}; ovfs[0] = 1'b1;
        vals[1] = 27'h5000000; exps[1] = {GD, GD, GD, GD, GD}; ovfs[1] = 1'b1;
        vals[2] = 27'h0C00000; exps[2] = {GB, G3, G0, G0, G0}; ovfs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_sample(1'b1, vals[i], lat, stable);
            nvec++; if (lat !== 10) begin nerr++; $display("[TB] FAIL sat%0d_latency got %0d want 10", i, lat); end
            nvec++; if (stable !== 1'b1) begin nerr++; $display("[TB] FAIL sat%0d_hold got unstable want stable", i); end
            nvec++; if (hex1 !== exps[i]) begin nerr++; $display("[TB] FAIL sat%0d_hex got %h want %h", i, hex1, exps[i]); end
            nvec++; if (ovf1 !== ovfs[i]) begin nerr++; $display("[TB] FAIL sat%0d_ovf got %b want %b", i, ovf1, ovfs[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [41:0] exps [3];
        int          when [3];
        logic [41:0] last;
        int          ndone;
        bit          stable;
        exps[0] = {GB, GB, G0, G0, G0, G0};
        exps[1] = {GB, GB, G5, G5, G0, G0};
        exps[2] = {GB, G1, G1, G0, G0, G0};
        ndone = 0;
        stable = 1'b1;
        last = hex0;
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            val0 = 27'(k) << 21;
            vld0 = 1'b1;
            @(posedge clk); #1;
            if (done0) begin
                if (ndone < 3) begin
                    when[ndone] = k;
                    nvec++; if (hex0 !== exps[ndone]) begin nerr++; $display("[TB] FAIL b2b%0d_hex got %h want %h", ndone, hex0, exps[ndone]); end
                end
                ndone++;
                last = hex0;
            end else if (hex0 !== last) begin
                stable = 1'b0;
            end
        end
        @(negedge clk);
        vld0 = 1'b0;
        nvec++; if (ndone !== 3) begin nerr++; $display("[TB] FAIL b2b_count got %0d want 3", ndone); end
        nvec++; if (stable !== 1'b1) begin nerr++; $display("[TB] FAIL b2b_hold got unstable want stable"); end
        if (ndone == 3) begin
            nvec++; if (when[0] !== 10 || when[1] !== 21 || when[2] !== 32) begin
                nerr++; $display("[TB] FAIL b2b_timing got %0d,%0d,%0d want 10,21,32", when[0], when[1], when[2]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit stable;
        bit quiet;
        @(negedge clk);
        for (int w = 0; w < 50 && !rdy0; w++) @(negedge clk);
        val0 = 27'h1D00000;
        vld0 = 1'b1;
        @(posedge clk); #1;
        vld0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        nvec++; if (hex0 !== {6{GB}}) begin nerr++; $display("[TB] FAIL abort_hex got %h want %h", hex0, {6{GB}}); end
        nvec++; if (done0 !== 1'b0 || ovf0 !== 1'b0) begin nerr++; $display("[TB] FAIL abort_flags got done=%b ovf=%b want 0 0", done0, ovf0); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("[TB] FAIL abort_ready got %b want 1", rdy0); end
        quiet = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done0 !== 1'b0 || hex0 !== {6{GB}}) quiet = 1'b0;
        end
        nvec++; if (quiet !== 1'b1) begin nerr++; $display("[TB] FAIL abort_partial got activity want none"); end
        run_sample(1'b0, 27'h1D00000, lat, stable);
        nvec++; if (lat !== 10) begin nerr++; $display("[TB] FAIL abort_next_latency got %0d want 10", lat); end
        nvec++; if (hex0 !== {GB, GB, G7, G2, G5, G0}) begin nerr++; $display("[TB] FAIL abort_next_hex got %h want %h", hex0, {GB, GB, G7, G2, G5, G0}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_fraction();
        test_saturation();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fixed_point_hex_display.md
FIXED_POINT_HEX_DISPLAY -- requirements
Module: fixed_point_hex_display

Interface
REQ-001 SHALL have parameter W, default 27, total width of the signed two's-complement input.
REQ-002 SHALL have parameter FRAC, default 22, number of fraction bits; integer width IW = W-FRAC, legal range 1..W-1.
REQ-003 SHALL have parameter INT_DIGITS, default 2, number of decimal integer digits displayed, legal range 1..4.
REQ-004 SHALL have parameter FRAC_DIGITS, default 3, number of decimal fraction digits displayed, legal range 0..4.
REQ-005 SHALL have parameter BLANK_LZ, default 1; when 1, leading integer zeros except the units digit are blanked.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: the value on `value` is offered.
REQ-009 SHALL have port value, input, W bits, signed fixed-point sample with FRAC fraction bits.
REQ-010 SHALL have port in_ready, output, 1 bit: high exactly when the FSM is in IDLE.
REQ-011 SHALL have port hex, output, ND x 7 bits: active-low segment codes, ND = 1+INT_DIGITS+FRAC_DIGITS. Index 0 is the last fraction digit; index ND-1 is the sign digit.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse in the cycle `hex` takes a new value.
REQ-013 SHALL have port ovf, output, 1 bit: registered; set when the displayed value saturated.

Function
REQ-014 SHALL accept a sample on a rising edge where in_valid and in_ready are both 1; other samples are ignored and never queued.
REQ-015 SHALL use FSM states IDLE -> ABS -> INT -> FRAC -> UPDATE -> IDLE.
REQ-016 SHALL, in ABS (1 cycle), latch the sign and the magnitude; the magnitude is W bits unsigned so that the most-negative input is exact.
REQ-017 SHALL, in INT (IW cycles), convert the integer magnitude to BCD by shift-add-3 at one bit per cycle.
REQ-018 SHALL, in FRAC (FRAC_DIGITS cycles, skipped if 0), multiply the fraction register by 10 once per cycle and take the bits above FRAC as the next digit; the result is truncated, never rounded.
REQ-019 SHALL, in UPDATE (1 cycle), register all ND digits and ovf atomically, pulse done, and then return to IDLE.
REQ-020 SHALL have a latency from the accept edge to `hex` update of exactly 2+IW+FRAC_DIGITS cycles; the default is 10.
REQ-021 SHALL use digit glyphs 0..9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; blank = 1111111; dash = 0111111.
REQ-022 SHALL drive the sign digit as dash whenever the input is negative (including a magnitude that truncates to zero) and blank otherwise.
REQ-023 SHALL saturate when the integer magnitude is at least 10^INT_DIGITS: every integer and fraction digit shows dash, the sign digit stays per REQ-022, and ovf = 1.
REQ-024 SHALL clear ovf at the UPDATE of the next non-saturating sample.
REQ-025 SHALL always show the units integer digit, even when it is 0.
REQ-026 SHALL hold `hex` and ovf steady between UPDATE cycles, whatever in_valid and value do.

Reset
REQ-027 SHALL, while reset is high, force the FSM to IDLE, every `hex` digit to blank (1111111), done = 0 and ovf = 0.
REQ-028 SHALL abort a conversion in progress when reset is asserted; no partial value is ever shown.
REQ-029 SHALL raise in_ready in the first cycle after reset releases.

Structure
REQ-030 SHALL place the glyph constants (0-9, blank, dash), the FSM state enum and a digit-to-glyph function in shared package seg7_pkg.
REQ-031 SHALL instantiate one sub-module, seg7_encode: a 4-bit BCD digit plus a blank flag in, 7-bit glyph out. It is instantiated per digit, combinational, and feeds the UPDATE registers.
REQ-032 SHALL keep the BCD and fraction working registers sized from the parameters; no width is hard-coded to 27/22.

Verification (defaults unless stated)
REQ-033 SHALL cover: value = 0x0440000 (1.0625) accepted -> 10 cycles later done = 1; hex = {blank, blank, 1111001, 1000000, 0000010, 0100100} ("1.062"); ovf = 0.
REQ-034 SHALL cover: value = -2.5 (0x7600000) -> sign digit = 0111111; digits "2.500" with tens blanked.
REQ-035 SHALL cover: INT_DIGITS = 1 and value = 12.0 -> all digit positions dash; sign blank; ovf = 1. A following 3.0 -> "3.000" with ovf = 0.
REQ-036 SHALL cover: most-negative input 0x4000000 (-16.0) -> sign dash; "16.000"; no ovf.
REQ-037 SHALL cover: in_valid held high with changing values -> exactly one accept per 11-cycle round trip (10 latency + 1 IDLE); intermediate values are dropped; `hex` is stable between done pulses.
REQ-038 SHALL cover: reset asserted during INT -> all `hex` digits blank immediately; in_ready = 1 after release; the next sample converts correctly.
